// File: rtl/flipper_pkg.sv
// Shared flipper definitions: register offsets,
// interrupt source indices, debouncer states.
package flipper_pkg;

  localparam int unsigned NUM_SRC = 14;

  localparam logic [9:0] OFS_INTSR   = 10'h000;
  localparam logic [9:0] OFS_INTMR   = 10'h001;
  localparam logic [9:0] OFS_CONSOLE = 10'h00B;

  localparam int unsigned SRC_GPERR    = 0;
  localparam int unsigned SRC_RSW      = 1;
  localparam int unsigned SRC_DI       = 2;
  localparam int unsigned SRC_SI       = 3;
  localparam int unsigned SRC_EXI      = 4;
  localparam int unsigned SRC_AI       = 5;
  localparam int unsigned SRC_DSP      = 6;
  localparam int unsigned SRC_MEM      = 7;
  localparam int unsigned SRC_VI       = 8;
  localparam int unsigned SRC_PETOKEN  = 9;
  localparam int unsigned SRC_PEFINISH = 10;
  localparam int unsigned SRC_CP       = 11;
  localparam int unsigned SRC_DEBUG    = 12;
  localparam int unsigned SRC_HSP      = 13;

  typedef enum logic {
    DB_STABLE   = 1'b0,
    DB_COUNTING = 1'b1
  } db_state_e;

endpackage

// File: rtl/pi_debounce.sv
// Reset-switch synchronizer and debounce FSM.
// rsw_rise pulses on the cycle rsw_state goes 0->1.
module pi_debounce
  import flipper_pkg::*;
#(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000
) (
  input  logic clk,
  input  logic resetn,
  input  logic sw_async,
  output logic rsw_state,
  output logic rsw_rise
);

  localparam logic [15:0] CNT_LAST =
    DEBOUNCE_CYCLES - 16'd1;

  logic        sync1_q, sync1_d;
  logic        sync2_q, sync2_d;
  logic        rsw_q, rsw_d;
  logic [15:0] cnt_q, cnt_d;
  db_state_e   state_q, state_d;

  // Next state: sync chain, stability counter.
  always_comb begin
    sync1_d  = sw_async;
    sync2_d  = sync1_q;
    state_d  = state_q;
    cnt_d    = cnt_q;
    rsw_d    = rsw_q;
    rsw_rise = 1'b0;
    unique case (state_q)
      DB_STABLE: begin
        if (sync2_q != rsw_q) begin
          state_d = DB_COUNTING;
          cnt_d   = 16'd0;
        end
      end
      DB_COUNTING: begin
        if (sync2_q == rsw_q) begin
          state_d = DB_STABLE;
        end else if (cnt_q == CNT_LAST) begin
          rsw_d    = sync2_q;
          state_d  = DB_STABLE;
          cnt_d    = 16'd0;
          rsw_rise = sync2_q;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
    endcase
  end

  // State register with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      rsw_q   <= 1'b0;
      cnt_q   <= 16'd0;
      state_q <= DB_STABLE;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      rsw_q   <= rsw_d;
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  assign rsw_state = rsw_q;

endmodule

// File: rtl/pi_interrupt_ctrl.sv
// Processor-interface interrupt controller:
// cause/mask registers, console ID, cpu_int.
module pi_interrupt_ctrl
  import flipper_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR       = 16'h3000,
  parameter logic [13:0] LEVEL_SRC       = 14'h0000,
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd1000,
  parameter logic [31:0] CONSOLE_TYPE    = 32'h1000_0006
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        CPURead,
  input  logic        CPUWrite,
  input  logic [15:0] CPUAddress,
  input  logic [31:0] CPUWriteData,
  output logic [31:0] CPUReadData,
  input  logic [13:0] irq_src,
  input  logic        reset_sw,
  output logic        cpu_int
);

  // The RSW slot is always sticky, never level.
  localparam logic [13:0] RSW_BIT =
    14'd1 << SRC_RSW;
  localparam logic [13:0] LVL =
    LEVEL_SRC & ~RSW_BIT;

  logic [13:0] cause_q, cause_d;
  logic [13:0] mask_q, mask_d;
  logic        int_q, int_d;

  logic        sel;
  logic [9:0]  ofs;
  logic        wr_intsr, wr_intmr;
  logic        rsw_state, rsw_rise;
  logic [13:0] set_v, clr_v, sticky_v;
  logic        unused_bits;

  assign sel = CPUAddress[15:12] == BASE_ADDR[15:12];
  assign ofs = CPUAddress[11:2];
  assign wr_intsr = CPUWrite && sel && ofs == OFS_INTSR;
  assign wr_intmr = CPUWrite && sel && ofs == OFS_INTMR;
  assign unused_bits =
    ^{CPURead, CPUWriteData[31:14], CPUAddress[1:0]};

  pi_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .resetn   (resetn),
    .sw_async (reset_sw),
    .rsw_state(rsw_state),
    .rsw_rise (rsw_rise)
  );

  // Read mux; zero when unselected or unmapped.
  always_comb begin
    CPUReadData = 32'h0;
    if (sel) begin
      unique case (ofs)
        OFS_INTSR:
          CPUReadData = {15'd0, rsw_state, 2'd0, cause_q};
        OFS_INTMR:
          CPUReadData = {18'd0, mask_q};
        OFS_CONSOLE:
          CPUReadData = CONSOLE_TYPE;
        default:
          CPUReadData = 32'h0;
      endcase
    end
  end

  // Cause/mask update; set wins over W1C clear.
  always_comb begin
    set_v          = irq_src;
    set_v[SRC_RSW] = rsw_rise;
    clr_v          = wr_intsr ? CPUWriteData[13:0] : 14'd0;
    sticky_v       = (cause_q & ~clr_v) | set_v;
    cause_d        = (LVL & irq_src) | (~LVL & sticky_v);
    mask_d         = wr_intmr ? CPUWriteData[13:0] : mask_q;
    int_d          = |(cause_q & mask_q);
  end

  // Register state with synchronous reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      cause_q <= 14'd0;
      mask_q  <= 14'd0;
      int_q   <= 1'b0;
    end else begin
      cause_q <= cause_d;
      mask_q  <= mask_d;
      int_q   <= int_d;
    end
  end

  assign cpu_int = int_q;

endmodule

// File: tb/tb_pi_interrupt_ctrl.sv
// Self-checking bench for pi_interrupt_ctrl:
// directed cases plus random traffic vs a model.
module tb_pi_interrupt_ctrl;

  localparam int DC = 8;
  localparam logic [13:0] LVL = 14'h0020;

  logic        clk = 1'b0;
  logic        resetn;
  logic        CPURead, CPUWrite;
  logic [15:0] CPUAddress;
  logic [31:0] CPUWriteData;
  logic [31:0] CPUReadData;
  logic [13:0] irq_src;
  logic        reset_sw;
  logic        cpu_int;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 1'b0;

  // reference model state
  logic [13:0] m_cause = '0;
  logic [13:0] m_mask  = '0;
  logic        m_int = 1'b0;
  logic        m_rsw = 1'b0;
  logic        m_s1 = 1'b0, m_s2 = 1'b0;
  int          run = 0;
  logic        rise, n_int, hit;

  always #5 clk = ~clk;

  pi_interrupt_ctrl #(
    .BASE_ADDR      (16'h3000),
    .LEVEL_SRC      (LVL),
    .DEBOUNCE_CYCLES(16'(DC)),
    .CONSOLE_TYPE   (32'h1000_0006)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .CPURead     (CPURead),
    .CPUWrite    (CPUWrite),
    .CPUAddress  (CPUAddress),
    .CPUWriteData(CPUWriteData),
    .CPUReadData (CPUReadData),
    .irq_src     (irq_src),
    .reset_sw    (reset_sw),
    .cpu_int     (cpu_int)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] exp_rd(
    input logic [15:0] a);
    if (a[15:12] != 4'h3) return 32'h0;
    case (a[11:2])
      10'd0:  return {15'd0, m_rsw, 2'd0, m_cause};
      10'd1:  return {18'd0, m_mask};
      10'd11: return 32'h1000_0006;
      default: return 32'h0;
    endcase
  endfunction

  // Model: sticky/level causes, switch must
  // differ from the stable value DC+1 edges.
  always @(posedge clk) begin
    if (!resetn) begin
      m_cause = '0; m_mask = '0; m_int = 1'b0;
      m_rsw = 1'b0; m_s1 = 1'b0; m_s2 = 1'b0;
      run = 0;
    end else begin
      n_int = |(m_cause & m_mask);
      rise = 1'b0;
      if (m_s2 != m_rsw) begin
        run++;
        if (run == DC + 1) begin
          m_rsw = m_s2;
          run = 0;
          rise = m_rsw;
        end
      end else begin
        run = 0;
      end
      m_s2 = m_s1;
      m_s1 = reset_sw;
      hit = CPUWrite && CPUAddress[15:12] == 4'h3;
      for (int n = 0; n < 14; n++) begin
        if (n == 1)
          m_cause[n] = (m_cause[n] &
            !(hit && CPUAddress[11:2] == 0 &&
              CPUWriteData[n])) | rise;
        else if (LVL[n])
          m_cause[n] = irq_src[n];
        else
          m_cause[n] = (m_cause[n] &
            !(hit && CPUAddress[11:2] == 0 &&
              CPUWriteData[n])) | irq_src[n];
      end
      if (hit && CPUAddress[11:2] == 10'd1)
        m_mask = CPUWriteData[13:0];
      m_int = n_int;
    end
  end

  // Continuous comparison against the model.
  always @(negedge clk) begin
    #1;
    if (chk_en) begin
      chk("auto_int", {31'd0, cpu_int}, {31'd0, m_int});
      chk("auto_rd", CPUReadData, exp_rd(CPUAddress));
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [15:0] a,
                    input logic [31:0] d);
    CPUWrite = 1'b1;
    CPUAddress = a;
    CPUWriteData = d;
    tick();
    CPUWrite = 1'b0;
  endtask

  task automatic rd(input string tag,
                    input logic [15:0] a,
                    input logic [31:0] exp);
    CPURead = 1'b1;
    CPUAddress = a;
    #1;
    chk(tag, CPUReadData, exp);
    CPURead = 1'b0;
  endtask

  logic [15:0] addrs [7] = '{16'h3000, 16'h3004,
    16'h302C, 16'h3010, 16'h4000, 16'h4004, 16'h3800};

  initial begin
    resetn = 1'b0;
    CPURead = 1'b0;
    CPUWrite = 1'b0;
    CPUAddress = 16'h3000;
    CPUWriteData = '0;
    irq_src = '0;
    reset_sw = 1'b0;
    tick(3);
    resetn = 1'b1;
    chk_en = 1'b1;
    rd("rst_intsr", 16'h3000, 32'h0);
    rd("rst_intmr", 16'h3004, 32'h0);
    chk("rst_int", {31'd0, cpu_int}, 32'h0);

    // pulse source on VI
    wr(16'h3004, 32'h100);
    irq_src = 14'h100;
    tick();
    irq_src = '0;
    rd("pulse_sr", 16'h3000, 32'h100);
    tick();
    chk("pulse_int", {31'd0, cpu_int}, 32'h1);
    wr(16'h3000, 32'h100);
    rd("pulse_clr", 16'h3000, 32'h0);
    tick();
    chk("pulse_int0", {31'd0, cpu_int}, 32'h0);

    // set and W1C clear in the same cycle
    irq_src = 14'h10;
    wr(16'h3000, 32'h10);
    irq_src = '0;
    rd("w1c_race", 16'h3000, 32'h10);
    wr(16'h3000, 32'h10);
    rd("w1c_clr", 16'h3000, 32'h0);

    // level source on AI
    irq_src = 14'h20;
    tick();
    rd("lvl_on", 16'h3000, 32'h20);
    wr(16'h3000, 32'h20);
    rd("lvl_w1c", 16'h3000, 32'h20);
    irq_src = '0;
    tick();
    rd("lvl_off", 16'h3000, 32'h0);

    // debounce: glitch, then a real press
    reset_sw = 1'b1;
    tick(5);
    reset_sw = 1'b0;
    tick(15);
    rd("db_glitch", 16'h3000, 32'h0);
    reset_sw = 1'b1;
    tick(12);
    rd("db_press", 16'h3000, 32'h0001_0002);
    reset_sw = 1'b0;
    tick(15);
    rd("db_release", 16'h3000, 32'h2);
    wr(16'h3000, 32'h2);
    rd("db_clr", 16'h3000, 32'h0);

    // address decoding
    rd("dec_cons", 16'h302C, 32'h1000_0006);
    rd("dec_unmap", 16'h3010, 32'h0);
    rd("dec_out", 16'h4000, 32'h0);
    wr(16'h3004, 32'hFFFF_FFFF);
    rd("dec_mask", 16'h3004, 32'h3FFF);
    wr(16'h302C, 32'h0);
    rd("dec_cons_ro", 16'h302C, 32'h1000_0006);
    wr(16'h4004, 32'h0);
    rd("dec_out_wr", 16'h3004, 32'h3FFF);

    // reset while debouncing
    irq_src = 14'h4;
    tick();
    irq_src = '0;
    reset_sw = 1'b1;
    tick(5);
    resetn = 1'b0;
    reset_sw = 1'b0;
    tick(2);
    resetn = 1'b1;
    rd("mid_sr", 16'h3000, 32'h0);
    rd("mid_mr", 16'h3004, 32'h0);
    chk("mid_int", {31'd0, cpu_int}, 32'h0);
    tick(15);
    rd("mid_sr2", 16'h3000, 32'h0);

    // random traffic
    for (int i = 0; i < 600; i++) begin
      irq_src = ($urandom_range(3) == 0) ?
        14'($urandom) : 14'd0;
      if ($urandom_range(19) == 0)
        reset_sw = ~reset_sw;
      CPUAddress = addrs[$urandom_range(6)];
      CPUWrite = ($urandom_range(3) == 0);
      CPURead = !CPUWrite;
      CPUWriteData = $urandom;
      tick();
    end
    CPUWrite = 1'b0;
    CPURead = 1'b0;
    tick(2);
    chk_en = 1'b0;

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
